// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the single-cycle MIPS subset core: opcode and funct
//   encodings, the ALU control enum, the decoded control bundle and the default
//   memory depths. Imported by mips_instr_mem and mips_single_cycle_cpu.
// -----------------------------------------------------------------------------
package mips_pkg;

  // Default memory depths in 32-bit words (powers of two so indices wrap).
  localparam int unsigned IMEM_WORDS_DEFAULT = 256;
  localparam int unsigned DMEM_WORDS_DEFAULT = 256;

  // Primary opcodes, instr[31:26].
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // R-type funct codes, instr[5:0].
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_e;

  // Decoded control for the instruction currently at pc.
  typedef struct packed {
    logic      reg_write;    // commit a register-file write this cycle
    logic      reg_dst_rd;   // destination is rd (R-type) instead of rt
    logic      alu_src_imm;  // ALU operand B is sext(imm) instead of rt
    logic      mem_write;    // store rt to data memory
    logic      mem_to_reg;   // write-back value comes from data memory
    logic      branch;       // beq: take branch when ALU result is zero
    logic      jump;         // j: absolute jump within the 256 MB region
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_instr_mem.sv
// -----------------------------------------------------------------------------
// mips_instr_mem
//   Read-only instruction memory with a combinational read. There is no write
//   port: the array `memory` is preloaded by hierarchical reference before the
//   core leaves reset. WORDS must be a power of two so the word index wraps.
//
//   Ports:
//     addr_i   in   word index (pc[..:2])
//     rdata_o  out  instruction word at addr_i
// -----------------------------------------------------------------------------
module mips_instr_mem
  import mips_pkg::*;
#(
  parameter int unsigned WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic [$clog2(WORDS)-1:0] addr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] memory [0:WORDS-1];

  assign rdata_o = memory[addr_i];

endmodule

// File: rtl/mips_single_cycle_cpu.sv
// -----------------------------------------------------------------------------
// mips_single_cycle_cpu
//   Single-cycle 32-bit MIPS subset core: add/sub/and/or, addi, lw, sw, beq, j.
//   Every instruction is fetched, decoded, executed and retired in one cycle.
//   Unsupported encodings (including 0x00000000) retire as no-ops with
//   pc <- pc+4. Register file is reset; instruction and data memories are not.
//
//   Build option: define MIPS_SLT_EN to add R-type slt (funct 0x2A). Without it
//   funct 0x2A is treated as an unsupported no-op.
//
//   Ports:
//     clk            in   rising-edge clock
//     reset          in   asynchronous, active-high reset
//     pc             out  current program counter
//     instruction    out  instruction word at pc
//     reg_t0..reg_t3 out  registers 8..11
//     mem_read_data  out  data memory word at alu_result (always, any opcode)
//     alu_result     out  ALU output
//     zero           out  alu_result == 0
// -----------------------------------------------------------------------------
module mips_single_cycle_cpu
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] reg_t0,
  output logic [31:0] reg_t1,
  output logic [31:0] reg_t2,
  output logic [31:0] reg_t3,
  output logic [31:0] mem_read_data,
  output logic [31:0] alu_result,
  output logic        zero
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_ext;

  ctrl_t       ctrl;

  logic [31:0] rf_q [0:31];
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_b, alu_y;
  logic        alu_zero;
  logic [4:0]  wr_addr;
  logic [31:0] wb_data;

  logic [31:0]    dmem [0:DMEM_WORDS-1];
  logic [DAW-1:0] dmem_idx;
  logic [31:0]    dmem_rdata;

  // ---------------------------------------------------------------------------
  // Fetch
  // ---------------------------------------------------------------------------
  mips_instr_mem #(
    .WORDS (IMEM_WORDS)
  ) IM (
    .addr_i  (pc_q[IAW+1:2]),
    .rdata_o (instr)
  );

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign imm     = instr[15:0];
  assign target  = instr[25:0];
  assign imm_ext = sext16(imm);

  always_comb begin
    // NOTE: every field is defaulted before the case so no path can infer a latch.
    ctrl             = '0;
    ctrl.alu_ctrl    = ALU_ADD;
    ctrl.alu_src_imm = 1'b1;
    case (opcode)
      OP_R: begin
        ctrl.alu_src_imm = 1'b0;
        ctrl.reg_dst_rd  = 1'b1;
        case (funct)
          FN_ADD: begin ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_ADD; end
          FN_SUB: begin ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_SUB; end
          FN_AND: begin ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_AND; end
          FN_OR:  begin ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_OR;  end
`ifdef MIPS_SLT_EN
          FN_SLT: begin ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_SLT; end
`endif
          default: ;  // unsupported funct: no write, pc+4
        endcase
      end
      OP_ADDI: ctrl.reg_write = 1'b1;
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW:   ctrl.mem_write = 1'b1;
      OP_BEQ: begin
        // Compare by subtraction; the zero flag decides the branch.
        ctrl.alu_src_imm = 1'b0;
        ctrl.alu_ctrl    = ALU_SUB;
        ctrl.branch      = 1'b1;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ;  // unsupported opcode: no write, pc+4
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file read (register 0 is hard-wired to zero)
  // ---------------------------------------------------------------------------
  assign rs_data = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_data = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  // ---------------------------------------------------------------------------
  // Execute
  // ---------------------------------------------------------------------------
  assign alu_b = ctrl.alu_src_imm ? imm_ext : rt_data;

  always_comb begin
    alu_y = 32'd0;
    case (ctrl.alu_ctrl)
      ALU_ADD: alu_y = rs_data + alu_b;
      ALU_SUB: alu_y = rs_data - alu_b;
      ALU_AND: alu_y = rs_data & alu_b;
      ALU_OR:  alu_y = rs_data | alu_b;
      ALU_SLT: alu_y = {31'd0, ($signed(rs_data) < $signed(alu_b))};
      default: alu_y = 32'd0;
    endcase
  end

  assign alu_zero = (alu_y == 32'd0);

  // ---------------------------------------------------------------------------
  // Data memory: combinational read at the ALU address, write on the edge
  // ---------------------------------------------------------------------------
  assign dmem_idx   = alu_y[DAW+1:2];
  assign dmem_rdata = dmem[dmem_idx];

  // NOTE: data memory is deliberately not reset; only the write is blocked
  // while reset is high so an aborted store cannot commit.
  always_ff @(posedge clk) begin
    if (ctrl.mem_write && !reset) begin
      dmem[dmem_idx] <= rt_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back
  // ---------------------------------------------------------------------------
  assign wr_addr = ctrl.reg_dst_rd ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? dmem_rdata : alu_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (ctrl.reg_write && (wr_addr != 5'd0)) begin
      rf_q[wr_addr] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next PC
  // ---------------------------------------------------------------------------
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jump) begin
      pc_d = {pc_plus4[31:28], target, 2'b00};
    end else if (ctrl.branch && alu_zero) begin
      pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples this cycle's values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug outputs
  // ---------------------------------------------------------------------------
  assign pc            = pc_q;
  assign instruction   = instr;
  assign reg_t0        = rf_q[8];
  assign reg_t1        = rf_q[9];
  assign reg_t2        = rf_q[10];
  assign reg_t3        = rf_q[11];
  assign mem_read_data = dmem_rdata;
  assign alu_result    = alu_y;
  assign zero          = alu_zero;

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// -----------------------------------------------------------------------------
// tb_mips_single_cycle_cpu
//   Self-checking bench for mips_single_cycle_cpu. An instruction-level
//   interpreter (architectural registers, data memory and pc as plain arrays)
//   runs in lockstep with the core; directed programs cover the arithmetic,
//   memory, branch, jump, $zero and reset cases, then random programs follow.
//   Honours MIPS_SLT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mips_single_cycle_cpu;

  logic        clk;
  logic        reset;
  logic [31:0] pc, instruction;
  logic [31:0] reg_t0, reg_t1, reg_t2, reg_t3;
  logic [31:0] mem_read_data, alu_result;
  logic        zero;

  bit clk_run;
  int n_tests;
  int n_fail;

  mips_single_cycle_cpu dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .instruction   (instruction),
    .reg_t0        (reg_t0),
    .reg_t1        (reg_t1),
    .reg_t2        (reg_t2),
    .reg_t3        (reg_t3),
    .mem_read_data (mem_read_data),
    .alu_result    (alu_result),
    .zero          (zero)
  );

  // Clock can be held idle (low) to observe purely asynchronous reset.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instruction encoders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: architectural state
  // ---------------------------------------------------------------------------
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  bit          m_dmem_valid;

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic load_word(input int idx, input logic [31:0] w);
    m_imem[idx] = w;
    dut.IM.memory[idx] = w;
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  // ALU value of the instruction at pc, where the ISA defines one.
  task automatic model_eval(output bit known, output logic [31:0] alu);
    logic [31:0] ins, a, b, s;
    ins   = m_imem[m_pc[9:2]];
    a     = m_regs[ins[25:21]];
    b     = m_regs[ins[20:16]];
    s     = sx(ins[15:0]);
    known = 1'b1;
    alu   = 32'd0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: alu = a + b;
          6'h22: alu = a - b;
          6'h24: alu = a & b;
          6'h25: alu = a | b;
`ifdef MIPS_SLT_EN
          6'h2A: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
          default: known = 1'b0;
        endcase
      end
      6'h08, 6'h23, 6'h2B: alu = a + s;
      6'h04:               alu = a - b;
      default:             known = 1'b0;
    endcase
  endtask

  task automatic model_step();
    logic [31:0] ins, b, s, npc, alu;
    bit          known;
    ins = m_imem[m_pc[9:2]];
    b   = m_regs[ins[20:16]];
    s   = sx(ins[15:0]);
    model_eval(known, alu);
    npc = m_pc + 32'd4;
    case (ins[31:26])
      6'h00: if (known) set_reg(ins[15:11], alu);
      6'h08: set_reg(ins[20:16], alu);
      6'h23: set_reg(ins[20:16], m_dmem[alu[9:2]]);
      6'h2B: m_dmem[alu[9:2]] = b;
      6'h04: if (m_regs[ins[25:21]] == b) npc = npc + (s << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc = npc;
  endtask

  // ---------------------------------------------------------------------------
  // Lockstep helpers (entered and left with clk low, mid-cycle)
  // ---------------------------------------------------------------------------
  task automatic compare_outputs();
    bit          known;
    logic [31:0] alu;
    model_eval(known, alu);
    check("pc", pc, m_pc);
    check("instruction", instruction, m_imem[m_pc[9:2]]);
    check("t0", reg_t0, m_regs[8]);
    check("t1", reg_t1, m_regs[9]);
    check("t2", reg_t2, m_regs[10]);
    check("t3", reg_t3, m_regs[11]);
    if (known) begin
      check("alu_result", alu_result, alu);
      check("zero", {31'd0, zero}, {31'd0, (alu == 32'd0)});
      if (m_dmem_valid) check("mem_read_data", mem_read_data, m_dmem[alu[9:2]]);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      compare_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_pc", pc, 32'd0);
    check("rst_t0", reg_t0, 32'd0);
    check("rst_t1", reg_t1, 32'd0);
    check("rst_t2", reg_t2, 32'd0);
    check("rst_t3", reg_t3, 32'd0);
    check("rst_instruction", instruction, m_imem[0]);
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Random program generation
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] rreg();
    int k;
    k = $urandom_range(0, 5);
    if (k == 0) return 5'd0;
    if (k <= 4) return 5'(7 + k);
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] base;
    base = ($urandom_range(0, 1) == 0) ? 5'd0 : rreg();
    case ($urandom_range(0, 11))
      0:  return enc_r(rreg(), rreg(), rreg(), 6'h20);
      1:  return enc_r(rreg(), rreg(), rreg(), 6'h22);
      2:  return enc_r(rreg(), rreg(), rreg(), 6'h24);
      3:  return enc_r(rreg(), rreg(), rreg(), 6'h25);
      4:  return enc_r(rreg(), rreg(), rreg(), 6'h2A);
      5:  return enc_i(6'h08, rreg(), rreg(), 16'($urandom_range(0, 65535)));
      6:  return enc_i(6'h23, base, rreg(), 16'($urandom_range(0, 31) * 4));
      7:  return enc_i(6'h2B, base, rreg(), 16'($urandom_range(0, 31) * 4));
      8:  return enc_i(6'h04, rreg(), rreg(), 16'($urandom_range(0, 6)) - 16'd3);
      9:  return enc_j(26'($urandom));
      10: return $urandom;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [31:0] exp_slt_a, exp_slt_b;

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b0;
    clk_run      = 1'b0;
    m_dmem_valid = 1'b0;
    for (int i = 0; i < 256; i++) m_dmem[i] = 32'd0;

    // Preamble program: sw $0, 4*i($0) for every word clears data memory.
    for (int i = 0; i < 256; i++) load_word(i, enc_i(6'h2B, 5'd0, 5'd0, 16'(i * 4)));
    model_reset();

    // Reset with the clock idle: purely asynchronous.
    #1 reset = 1'b1;
    #1;
    check("idle_rst_pc", pc, 32'd0);
    check("idle_rst_t0", reg_t0, 32'd0);
    check("idle_rst_t1", reg_t1, 32'd0);
    check("idle_rst_t2", reg_t2, 32'd0);
    check("idle_rst_t3", reg_t3, 32'd0);
    check("idle_rst_instruction", instruction, m_imem[0]);
    #1 reset = 1'b0;
    clk_run = 1'b1;

    run_cycles(256);
    m_dmem_valid = 1'b1;

    // Directed program 1.
    for (int i = 0; i < 256; i++) load_word(i, 32'd0);
    load_word(0, enc_i(6'h08, 5'd0, 5'd9, 16'd5));        // addi $t1,$0,5
    load_word(1, enc_i(6'h08, 5'd0, 5'd10, 16'd10));      // addi $t2,$0,10
    load_word(2, enc_r(5'd9, 5'd10, 5'd8, 6'h20));        // add  $t0,$t1,$t2
    load_word(3, enc_r(5'd9, 5'd10, 5'd8, 6'h22));        // sub
    load_word(4, enc_r(5'd9, 5'd10, 5'd8, 6'h24));        // and
    load_word(5, enc_r(5'd9, 5'd10, 5'd8, 6'h25));        // or
    load_word(6, enc_i(6'h2B, 5'd0, 5'd10, 16'd0));       // sw $t2,0($0)
    load_word(7, enc_i(6'h23, 5'd0, 5'd11, 16'd0));       // lw $t3,0($0)
    load_word(8, enc_i(6'h04, 5'd11, 5'd9, 16'd2));       // beq $t3,$t1,2
    load_word(9, enc_j(26'd0));                           // j 0
    apply_reset();

    run_cycles(3);
    check("addi_t1", reg_t1, 32'h5);
    check("addi_t2", reg_t2, 32'hA);
    check("add_t0", reg_t0, 32'hF);
    run_cycles(1);
    check("sub_t0", reg_t0, 32'hFFFF_FFFB);
    run_cycles(1);
    check("and_t0", reg_t0, 32'h0);
    run_cycles(1);
    check("or_t0", reg_t0, 32'hF);
    run_cycles(1);
    check("lw_pc", pc, 32'h1C);
    check("lw_mem_read_data", mem_read_data, 32'hA);
    run_cycles(1);
    check("lw_t3", reg_t3, 32'hA);
    run_cycles(1);
    check("beq_not_taken_pc", pc, 32'h24);
    run_cycles(1);
    check("j_pc", pc, 32'h0);

    // Directed program 2: taken branch, write to $0, slt.
    load_word(8,  enc_i(6'h04, 5'd9, 5'd9, 16'd2));       // beq $t1,$t1,2
    load_word(11, enc_i(6'h08, 5'd0, 5'd0, 16'd7));       // addi $0,$0,7
    load_word(12, enc_r(5'd0, 5'd0, 5'd11, 6'h20));       // add $t3,$0,$0
    load_word(13, enc_r(5'd10, 5'd9, 5'd8, 6'h2A));       // slt $t0,$t2,$t1
    load_word(14, enc_r(5'd9, 5'd10, 5'd8, 6'h2A));       // slt $t0,$t1,$t2
    apply_reset();

    run_cycles(9);
    check("beq_taken_pc", pc, 32'h2C);
    run_cycles(2);
    check("zero_reg_t3", reg_t3, 32'h0);
`ifdef MIPS_SLT_EN
    exp_slt_a = 32'd0;
    exp_slt_b = 32'd1;
`else
    exp_slt_a = 32'hF;
    exp_slt_b = 32'hF;
`endif
    run_cycles(1);
    check("slt_false_t0", reg_t0, exp_slt_a);
    run_cycles(1);
    check("slt_true_t0", reg_t0, exp_slt_b);

    // Reset pulsed mid-run and held across edges with a store at IM[0].
    load_word(0, enc_i(6'h2B, 5'd0, 5'd0, 16'd0));        // sw $0,0($0)
    reset = 1'b1;
    #1;
    check("midrun_rst_pc", pc, 32'd0);
    check("midrun_rst_t0", reg_t0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_pc", pc, 32'd0);
    check("rst_no_dmem_write", mem_read_data, 32'hA);
    model_reset();
    #1 reset = 1'b0;
    run_cycles(4);

    // Random programs.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) load_word(i, rand_instr());
      apply_reset();
      run_cycles(200);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
